// File: rtl/game_timer_pkg.sv
// Shared types, widths and helpers for the game_timer block.
package game_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;

  localparam int TIME_W = 7;

  // Split a 0..99 seconds value into {tens, ones} BCD digits.
  function automatic logic [7:0] to_bcd(input logic [TIME_W-1:0] t);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(t / TIME_W'(10));
    ones = 4'(t % TIME_W'(10));
    return {tens, ones};
  endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control and display bundle between game control and the round timer.
interface game_timer_if;
  import game_timer_pkg::*;

  logic              clk_1Hz;
  logic              start;
  logic              pause;
  logic              reload;
  logic [TIME_W-1:0] time_left;
  logic [3:0]        bcd_tens;
  logic [3:0]        bcd_ones;
  logic              running;
  logic              expired;
  logic              warn_blink;

  // Game control side: drives the controls, observes the timer.
  modport master (
    output clk_1Hz, start, pause, reload,
    input  time_left, bcd_tens, bcd_ones, running, expired, warn_blink
  );

  // Timer side.
  modport slave (
    input  clk_1Hz, start, pause, reload,
    output time_left, bcd_tens, bcd_ones, running, expired, warn_blink
  );
endinterface

// File: rtl/game_timer_tick_edge.sv
// Brings the slow 1 Hz square wave into the Clk domain and turns each
// rising edge into a single-cycle tick. level is the synchronized wave.
module tick_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic din,
  output logic tick,
  output logic level
);
  logic s1_q, s2_q, s3_q;

  // Two-flop synchronizer followed by one delay flop for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick  = s2_q & ~s3_q;
  assign level = s2_q;
endmodule

// File: rtl/game_timer.sv
// Frogger round countdown timer: counts START_SECS down on each 1 Hz tick,
// with pause/reload, BCD display digits and a one-cycle expiry pulse.
// Optional 1 Hz warning blink when built with GAME_TIMER_WARN_EN.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int START_SECS = 60,
  parameter int WARN_SECS  = 10
) (
  input  logic         Clk,
  input  logic         Reset_n,
  game_timer_if.slave  bus
);
  localparam logic [TIME_W-1:0] START_T = TIME_W'(START_SECS);

  timer_state_t      state_q;
  logic [TIME_W-1:0] time_q;
  logic              running_q;
  logic              expired_q;
  logic              tick_w;
  logic              level_w;
  logic [7:0]        bcd_w;

  tick_edge u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .din     (bus.clk_1Hz),
    .tick    (tick_w),
    .level   (level_w)
  );

  // Round FSM and seconds counter; priority reload > pause > tick > start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      time_q    <= START_T;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (bus.reload) begin
        state_q   <= IDLE;
        time_q    <= START_T;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state_q   <= PAUSED;
              running_q <= 1'b0;
            end else if (tick_w) begin
              if (time_q > TIME_W'(1)) begin
                time_q <= time_q - TIME_W'(1);
              end else begin
                time_q    <= '0;
                expired_q <= 1'b1;
                state_q   <= EXPIRED;
                running_q <= 1'b0;
              end
            end
          end
          PAUSED: begin
            if (!bus.pause) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          EXPIRED: begin
            time_q <= '0;
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bcd_w         = to_bcd(time_q);
  assign bus.time_left = time_q;
  assign bus.bcd_tens  = bcd_w[7:4];
  assign bus.bcd_ones  = bcd_w[3:0];
  assign bus.running   = running_q;
  assign bus.expired   = expired_q;

`ifdef GAME_TIMER_WARN_EN
  localparam logic [TIME_W-1:0] WARN_T = TIME_W'(WARN_SECS);
  // Blink at 1 Hz during the last WARN_SECS seconds of a running round.
  assign bus.warn_blink = running_q && (time_q != '0) && (time_q <= WARN_T) && level_w;
`else
  // Warning disabled: expression is constant 0, no logic is built.
  assign bus.warn_blink = level_w & (WARN_SECS < 0);
`endif
endmodule
